dds_triangle_skew_ctrl: RTL and testbench
=========================================

# dds_triangle_skew_ctrl

Configuration sequencer for the DDS triangle generator. Accepts a requested symmetry point, computes the rising and falling slope coefficients with a shared sequential restoring divider, and presents the three skew words to the triangle datapath. All three words update atomically, either immediately or at the next phase wrap, so the triangle never runs with a mismatched apex/slope set.

## Interface
- SYNC_TO_WRAP, 1: 1 = commit new skew set only on phase wrap; 0 = commit as soon as division completes.
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- Phase  in  18  phase word currently driving the triangle datapath; used for wrap detection.
- Symmetry  in  18  requested apex position (new Skew0).
- Load  in  1  single-cycle request strobe; Symmetry is sampled when Load=1.
- Busy  out  1  high whenever the state is not IDLE.
- Updated  out  1  one-cycle pulse on the cycle after a commit.
- Skew0  out  18  apex phase.
- Skew1  out  18  rising slope coefficient.
- Skew2  out  18  falling slope coefficient.

## Operation
- Reset values: Skew0=18'h20000, Skew1=1024, Skew2=1024 (symmetric triangle); Busy=0; Updated=0; pending flag clear; Phase_q=0; state IDLE.
- Arithmetic:
  - Skew1 = floor(2^27 / S).
  - Skew2 = floor(2^27 / (2^18 − S)). The divisor is 19 bits wide.
  - S is the sampled Symmetry.
  - Any quotient > 18'h3FFFF saturates to 18'h3FFFF.
  - Divide by zero (S=0 for Skew1) yields 18'h3FFFF.
- Divider: restoring, one quotient bit per cycle, 28 iterations per quotient, single instance shared by both divisions.
- States:
  - IDLE: Load=1 → capture S, go to DIV_RISE.
  - DIV_RISE: 28 cycles, then go to DIV_FALL.
  - DIV_FALL: 28 cycles. Then go to WAIT_WRAP if SYNC_TO_WRAP=1, else to COMMIT.
  - WAIT_WRAP: wrap detected → commit on this edge. Then go to IDLE, or to DIV_RISE if pending.
  - COMMIT: one cycle; commit, then go to IDLE (or DIV_RISE if pending).
- Wrap detect:
  - Phase_q is registered every cycle.
  - wrap = (Phase < Phase_q), evaluated combinationally.
  - A stopped phase (constant value) never wraps, so the block stays in WAIT_WRAP indefinitely. This is intended.
- Commit: Skew0/Skew1/Skew2 load on the same edge, from shadow registers. They never change outside a commit.
- Load while Busy:
  - Latch Symmetry into a one-deep pending register; the latest Load wins.
  - On commit, a set pending flag starts a new computation immediately. Busy stays high.
- Load on the commit edge: treated as pending, and overrides any older pending value.
- Reset mid-computation: abort, discard shadow and pending values, restore reset values. No Updated pulse.

## Timing
- Load sampled at edge 0:
  - Busy high from edge 0.
  - Rise iterations at edges 1–28; fall iterations at edges 29–56.
- SYNC_TO_WRAP=0:
  - Skew outputs change at edge 57.
  - Updated=1 for the cycle after edge 57.
  - Busy=0 after edge 57 if nothing is pending.
- SYNC_TO_WRAP=1: commit occurs at the first edge ≥ 57 where wrap=1. Updated follows one cycle later.
- Back-to-back: with a pending request, the next rise phase starts at the edge after commit. Busy has no low gap.
- Updated is never asserted for more than one consecutive cycle.

## Test plan
- Reset, then idle: Skew0=20000h, Skew1=400h, Skew2=400h, Busy=0, Updated=0.
- SYNC_TO_WRAP=0, Load with Symmetry=10000h at edge 0 → at edge 57: Skew0=10000h, Skew1=800h, Skew2=2AAh; Updated pulses once.
- Boundaries:
  - Symmetry=0 → Skew1=3FFFFh, Skew2=200h.
  - Symmetry=3FFFFh → Skew1=200h, Skew2=3FFFFh.
  - Symmetry=100h → Skew1=3FFFFh (saturated).
- SYNC_TO_WRAP=1, Phase ramping +1000h/cycle, Load=30000h:
  - Outputs hold the old values until the first edge with Phase < Phase_q after edge 56.
  - With Phase held constant, the block stays Busy with outputs unchanged.
- Pending requests:
  - Load A=8000h, then Load B=18000h and C=28000h during Busy → two commits (A, then C); B is never output.
  - Busy stays continuously high; two Updated pulses.
- Assert Reset at edge 30 of a computation → all outputs return to reset values; no Updated pulse; a fresh Load afterwards completes normally in 57 cycles.

Source files
------------

// File: rtl/dds_triangle_skew_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dds_triangle_skew_ctrl_if
//  Purpose  : Request/skew-word bundle between the triangle datapath and the
//             skew configuration sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface dds_triangle_skew_ctrl_if;
  logic [17:0] Phase;
  logic [17:0] Symmetry;
  logic        Load;
  logic        Busy;
  logic        Updated;
  logic [17:0] Skew0;
  logic [17:0] Skew1;
  logic [17:0] Skew2;

  modport master (
    output Phase, Symmetry, Load,
    input  Busy, Updated, Skew0, Skew1, Skew2
  );

  modport slave (
    input  Phase, Symmetry, Load,
    output Busy, Updated, Skew0, Skew1, Skew2
  );
endinterface
`default_nettype wire

// File: rtl/dds_triangle_skew_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dds_triangle_skew_ctrl
//  Purpose  : Turns a requested apex position into the apex/rise/fall skew set
//             using one shared restoring divider, and commits all three words
//             together (immediately or on the next phase wrap).
//  Revision : 1.0  initial release
// ============================================================================
module dds_triangle_skew_ctrl #(
  parameter logic SYNC_TO_WRAP = 1'b1
) (
  input  wire logic               Clk,
  input  wire logic               Reset,
  dds_triangle_skew_ctrl_if.slave bus
);

  localparam logic [2:0]  c_IDLE      = 3'd0;
  localparam logic [2:0]  c_DIV_RISE  = 3'd1;
  localparam logic [2:0]  c_DIV_FALL  = 3'd2;
  localparam logic [2:0]  c_WAIT_WRAP = 3'd3;
  localparam logic [2:0]  c_COMMIT    = 3'd4;
  localparam logic [4:0]  c_LAST_IT   = 5'd27;
  localparam logic [17:0] c_QMAX      = 18'h3FFFF;
  localparam logic [18:0] c_FULL      = 19'h40000;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [17:0] r_phase_q;
  logic [4:0]  r_cnt;
  logic [18:0] r_rem;
  logic [27:0] r_quo;
  logic [18:0] r_div;
  logic [17:0] r_sh0;
  logic [17:0] r_sh1;
  logic [17:0] r_sh2;
  logic        r_pend;
  logic [17:0] r_pend_sym;
  logic [17:0] r_skew0;
  logic [17:0] r_skew1;
  logic [17:0] r_skew2;
  logic        r_updated;

  logic        w_wrap;
  logic        w_commit;
  logic        w_busy;
  logic        w_last;
  logic        w_start;
  logic [17:0] w_start_sym;
  logic [19:0] w_trial;
  logic        w_ge;
  logic [18:0] w_rem_sub;
  logic [18:0] w_rem_next;
  logic [27:0] w_quo_next;
  logic [17:0] w_quo_sat;

  // A falling phase value means the accumulator rolled over since last cycle.
  assign w_wrap = (bus.Phase < r_phase_q);
  assign w_last = (r_cnt == c_LAST_IT);

  // Dividend is 2^27: only its MSB (consumed on the first iteration) is set.
  assign w_trial    = {r_rem, (r_cnt == 5'd0)};
  assign w_ge       = (w_trial >= {1'b0, r_div});
  assign w_rem_sub  = w_trial[18:0] - r_div;
  assign w_rem_next = w_ge ? w_rem_sub : w_trial[18:0];
  assign w_quo_next = {r_quo[26:0], w_ge};
  // A zero divisor yields all-ones, which saturates like any oversize quotient.
  assign w_quo_sat  = (|w_quo_next[27:18]) ? c_QMAX : w_quo_next[17:0];

  // A new computation starts from IDLE, or straight out of a commit when a
  // request is waiting; a Load on the commit edge is the newest request.
  assign w_start     = ((r_state == c_IDLE) && bus.Load) || (w_commit && (bus.Load || r_pend));
  assign w_start_sym = bus.Load ? bus.Symmetry : r_pend_sym;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= c_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:      if (bus.Load) w_next_state = c_DIV_RISE;
      c_DIV_RISE:  if (w_last) w_next_state = c_DIV_FALL;
      c_DIV_FALL:  if (w_last) w_next_state = SYNC_TO_WRAP ? c_WAIT_WRAP : c_COMMIT;
      c_WAIT_WRAP: if (w_wrap) w_next_state = (bus.Load || r_pend) ? c_DIV_RISE : c_IDLE;
      c_COMMIT:    w_next_state = (bus.Load || r_pend) ? c_DIV_RISE : c_IDLE;
      default:     w_next_state = c_IDLE;
    endcase
  end

  // State-derived outputs: busy flag and the commit strobe.
  always_comb begin
    w_busy   = (r_state != c_IDLE);
    w_commit = (r_state == c_COMMIT) || ((r_state == c_WAIT_WRAP) && w_wrap);
  end

  // Divider, shadow set, pending request and committed skew words.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_phase_q  <= 18'd0;
      r_cnt      <= 5'd0;
      r_rem      <= 19'd0;
      r_quo      <= 28'd0;
      r_div      <= 19'd0;
      r_sh0      <= 18'h20000;
      r_sh1      <= 18'd1024;
      r_sh2      <= 18'd1024;
      r_pend     <= 1'b0;
      r_pend_sym <= 18'd0;
      r_skew0    <= 18'h20000;
      r_skew1    <= 18'd1024;
      r_skew2    <= 18'd1024;
      r_updated  <= 1'b0;
    end else begin
      r_phase_q <= bus.Phase;
      r_updated <= w_commit;

      if (w_commit) begin
        r_skew0 <= r_sh0;
        r_skew1 <= r_sh1;
        r_skew2 <= r_sh2;
      end

      if (w_start) begin
        r_pend <= 1'b0;
      end else if (bus.Load && w_busy) begin
        r_pend     <= 1'b1;
        r_pend_sym <= bus.Symmetry;
      end

      if (w_start) begin
        r_sh0 <= w_start_sym;
        r_div <= {1'b0, w_start_sym};
        r_rem <= 19'd0;
        r_quo <= 28'd0;
        r_cnt <= 5'd0;
      end else if ((r_state == c_DIV_RISE) || (r_state == c_DIV_FALL)) begin
        if (w_last) begin
          r_cnt <= 5'd0;
          r_rem <= 19'd0;
          r_quo <= 28'd0;
          if (r_state == c_DIV_RISE) begin
            r_sh1 <= w_quo_sat;
            r_div <= c_FULL - {1'b0, r_sh0};
          end else begin
            r_sh2 <= w_quo_sat;
          end
        end else begin
          r_cnt <= r_cnt + 5'd1;
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
        end
      end
    end
  end

  assign bus.Busy    = w_busy;
  assign bus.Updated = r_updated;
  assign bus.Skew0   = r_skew0;
  assign bus.Skew1   = r_skew1;
  assign bus.Skew2   = r_skew2;

endmodule
`default_nettype wire

// File: tb/tb_dds_triangle_skew_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_triangle_skew_ctrl
//  Purpose  : Self-checking bench; one instance commits immediately, the other
//             waits for a phase wrap. A transaction-level model predicts the
//             skew words, Busy and Updated after every clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dds_triangle_skew_ctrl;

  localparam int          MAXC  = 256;
  localparam logic [53:0] c_RST = {18'h20000, 18'h00400, 18'h00400};

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  dds_triangle_skew_ctrl_if if_imm ();
  dds_triangle_skew_ctrl_if if_wrp ();

  dds_triangle_skew_ctrl #(.SYNC_TO_WRAP(1'b0)) u_imm (.Clk(Clk), .Reset(Reset), .bus(if_imm.slave));
  dds_triangle_skew_ctrl #(.SYNC_TO_WRAP(1'b1)) u_wrp (.Clk(Clk), .Reset(Reset), .bus(if_wrp.slave));

  int n_vec = 0;
  int n_err = 0;

  bit          ld_en  [MAXC];
  logic [17:0] ld_sym [MAXC];
  logic [17:0] ph     [MAXC];
  logic [53:0] mdl_out [2];
  logic [17:0] last_ph [2];

  // Single comparison point.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected {apex, rise, fall} for a requested symmetry point.
  function automatic logic [53:0] ref_skews(input logic [17:0] s);
    longint q1, q2;
    if (s == 18'd0) q1 = 64'h3FFFF;
    else            q1 = (64'sd1 <<< 27) / longint'(s);
    q2 = (64'sd1 <<< 27) / (64'sd262144 - longint'(s));
    if (q1 > 64'h3FFFF) q1 = 64'h3FFFF;
    if (q2 > 64'h3FFFF) q2 = 64'h3FFFF;
    return {s, q1[17:0], q2[17:0]};
  endfunction

  task automatic drive(input int d, input logic ld, input logic [17:0] s, input logic [17:0] p);
    if (d == 0) begin if_imm.Load = ld; if_imm.Symmetry = s; if_imm.Phase = p; end
    else        begin if_wrp.Load = ld; if_wrp.Symmetry = s; if_wrp.Phase = p; end
  endtask

  task automatic sample(input int d, output logic busy, output logic upd, output logic [53:0] sk);
    if (d == 0) begin busy = if_imm.Busy; upd = if_imm.Updated; sk = {if_imm.Skew0, if_imm.Skew1, if_imm.Skew2}; end
    else        begin busy = if_wrp.Busy; upd = if_wrp.Updated; sk = {if_wrp.Skew0, if_wrp.Skew1, if_wrp.Skew2}; end
  endtask

  task automatic clear_stim(input logic [17:0] p);
    for (int e = 0; e < MAXC; e++) begin
      ld_en[e] = 1'b0; ld_sym[e] = 18'd0; ph[e] = p;
    end
  endtask

  // Predict per-edge outputs from the request/commit rules, then replay the
  // stimulus on the chosen instance and compare after every edge.
  task automatic run_case(input int d, input int ncyc, input string name);
    bit          eb [MAXC];
    bit          eu [MAXC];
    logic [53:0] es [MAXC];
    bit          act, pend, ok;
    int          t0;
    logic [17:0] cur, pv, prevp;
    logic [53:0] outv;
    logic        busy, upd;
    logic [53:0] sk;
    act = 0; pend = 0; t0 = 0; cur = 0; pv = 0;
    prevp = last_ph[d];
    outv  = mdl_out[d];
    for (int e = 0; e < ncyc; e++) begin
      eu[e] = 1'b0;
      if (!act) begin
        if (ld_en[e]) begin act = 1; cur = ld_sym[e]; t0 = e; end
      end else begin
        ok = (e >= t0 + 57) && ((d == 0) || (ph[e] < prevp));
        if (ok) begin
          outv  = ref_skews(cur);
          eu[e] = 1'b1;
          if (ld_en[e])  begin cur = ld_sym[e]; t0 = e; pend = 0; end
          else if (pend) begin cur = pv; t0 = e; pend = 0; end
          else           act = 0;
        end else if (ld_en[e]) begin
          pend = 1; pv = ld_sym[e];
        end
      end
      prevp = ph[e];
      eb[e] = act;
      es[e] = outv;
    end
    for (int e = 0; e < ncyc; e++) begin
      drive(d, ld_en[e], ld_sym[e], ph[e]);
      @(posedge Clk);
      #1;
      sample(d, busy, upd, sk);
      chk($sformatf("%s busy@%0d", name, e), 64'(busy), 64'(eb[e]));
      chk($sformatf("%s updated@%0d", name, e), 64'(upd), 64'(eu[e]));
      chk($sformatf("%s skews@%0d", name, e), 64'(sk), 64'(es[e]));
    end
    drive(d, 1'b0, 18'd0, ph[ncyc-1]);
    last_ph[d] = ph[ncyc-1];
    mdl_out[d] = outv;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic        b, u;
    logic [53:0] sk;
    logic [17:0] bvals [4];
    logic [17:0] st;
    int          e;

    drive(0, 1'b0, 18'd0, 18'd0);
    drive(1, 1'b0, 18'd0, 18'd0);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    mdl_out[0] = c_RST; mdl_out[1] = c_RST;
    last_ph[0] = 18'd0; last_ph[1] = 18'd0;

    for (int d = 0; d < 2; d++) begin
      sample(d, b, u, sk);
      chk($sformatf("reset skews d%0d", d), 64'(sk), 64'(c_RST));
      chk($sformatf("reset busy d%0d", d), 64'(b), 64'd0);
      chk($sformatf("reset updated d%0d", d), 64'(u), 64'd0);
    end

    // Nominal and boundary symmetry points, immediate commit.
    bvals = '{18'h10000, 18'h00000, 18'h3FFFF, 18'h00100};
    foreach (bvals[i]) begin
      clear_stim(18'd0);
      ld_en[0] = 1'b1; ld_sym[0] = bvals[i];
      run_case(0, 62, $sformatf("imm_%0h", bvals[i]));
    end
    chk("ref 10000h", 64'(ref_skews(18'h10000)), 64'({18'h10000, 18'h00800, 18'h002AA}));

    // Random single requests.
    for (int k = 0; k < 4; k++) begin
      clear_stim(18'd0);
      ld_en[0] = 1'b1; ld_sym[0] = 18'($urandom_range(0, 18'h3FFFF));
      run_case(0, 60, $sformatf("imm_rand%0d", k));
    end

    // Pending requests: A, then B and C while busy; C replaces B.
    clear_stim(18'd0);
    ld_en[0]  = 1'b1; ld_sym[0]  = 18'h08000;
    ld_en[10] = 1'b1; ld_sym[10] = 18'h18000;
    ld_en[20] = 1'b1; ld_sym[20] = 18'h28000;
    run_case(0, 120, "pend_abc");

    // A Load on the commit edge overrides an older pending request.
    clear_stim(18'd0);
    ld_en[0]  = 1'b1; ld_sym[0]  = 18'h04000;
    ld_en[15] = 1'b1; ld_sym[15] = 18'h1C000;
    ld_en[57] = 1'b1; ld_sym[57] = 18'h34000;
    run_case(0, 120, "pend_commit_edge");

    // Random request bursts.
    for (int k = 0; k < 3; k++) begin
      clear_stim(18'd0);
      ld_en[0] = 1'b1; ld_sym[0] = 18'($urandom_range(0, 18'h3FFFF));
      for (int j = 0; j < 3; j++) begin
        e = int'($urandom_range(1, 113));
        ld_en[e] = 1'b1; ld_sym[e] = 18'($urandom_range(0, 18'h3FFFF));
      end
      run_case(0, 235, $sformatf("burst_rand%0d", k));
    end

    // Wrap-synchronised commit with a ramping phase.
    clear_stim(18'd0);
    for (int i = 0; i < MAXC; i++) ph[i] = 18'(i * 32'h1000);
    ld_en[0] = 1'b1; ld_sym[0] = 18'h30000;
    run_case(1, 130, "wrap_30000");

    for (int k = 0; k < 3; k++) begin
      st = 18'($urandom_range(0, 18'h3FFFF));
      clear_stim(18'd0);
      for (int i = 0; i < MAXC; i++) ph[i] = st + 18'(i * 32'h1000);
      ld_en[0] = 1'b1; ld_sym[0] = 18'($urandom_range(0, 18'h3FFFF));
      ld_en[70] = ($urandom_range(0, 1) == 1);
      ld_sym[70] = 18'($urandom_range(0, 18'h3FFFF));
      run_case(1, 200, $sformatf("wrap_rand%0d", k));
    end

    // Stopped phase: stays busy with outputs held until the phase drops.
    clear_stim(18'h20000);
    for (int i = 150; i < MAXC; i++) ph[i] = 18'h00100;
    ld_en[0] = 1'b1; ld_sym[0] = 18'h0C000;
    run_case(1, 156, "wrap_stopped");

    // Reset in the middle of a computation.
    drive(0, 1'b1, 18'h03000, 18'd0);
    @(posedge Clk); #1;
    drive(0, 1'b0, 18'd0, 18'd0);
    repeat (29) @(posedge Clk);
    #1;
    sample(0, b, u, sk);
    chk("midrst busy before", 64'(b), 64'd1);
    chk("midrst skews before", 64'(sk), 64'(mdl_out[0]));
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    sample(0, b, u, sk);
    chk("midrst skews", 64'(sk), 64'(c_RST));
    chk("midrst busy", 64'(b), 64'd0);
    chk("midrst updated", 64'(u), 64'd0);
    @(posedge Clk); #1;
    sample(0, b, u, sk);
    chk("midrst updated after", 64'(u), 64'd0);
    chk("midrst skews after", 64'(sk), 64'(c_RST));
    mdl_out[0] = c_RST; mdl_out[1] = c_RST;

    clear_stim(18'd0);
    ld_en[0] = 1'b1; ld_sym[0] = 18'($urandom_range(0, 18'h3FFFF));
    run_case(0, 60, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
